// File: rtl/am2302_pkg.sv
`timescale 1ns/1ps
// am2302_pkg
// Shared types and helpers for the AM2302 single-wire protocol engine:
//   - am2302_state_e : protocol FSM states
//   - FRAME_BITS     : sensor frame width (40 bits)
//   - *_MSB / *_LSB  : byte-field positions inside the received frame
//   - am2302_checksum: 8-bit sum of the four data bytes (mod 256)
package am2302_pkg;

    typedef enum logic [3:0] {
        IDLE,
        START_LOW,
        WAIT_RESP,
        RESP_LOW,
        RESP_HIGH,
        BIT_LOW,
        BIT_HIGH,
        CHECK,
        DONE
    } am2302_state_e;

    localparam int FRAME_BITS = 40;

    // Frame layout, MSB first as received: humidity, temperature, checksum.
    localparam int HUM_MSB  = 39;
    localparam int HUM_LSB  = 24;
    localparam int TEMP_MSB = 23;
    localparam int TEMP_LSB = 8;
    localparam int CSUM_MSB = 7;
    localparam int CSUM_LSB = 0;

    // The 8-bit result width performs the mod-256 wrap.
    function automatic logic [7:0] am2302_checksum(input logic [FRAME_BITS-1:0] frame);
        return frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
    endfunction

endpackage

// File: rtl/am2302_us_tick.sv
`timescale 1ns/1ps
// am2302_us_tick
// Free-running divider producing a one-cycle pulse every DIV clock cycles.
// Ports:
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   o_tick  : one-cycle pulse every DIV cycles
module am2302_us_tick #(
    parameter int unsigned DIV = 100
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    // With DIV == 1 the counter stays at zero and the tick is permanently high.
    assign w_wrap = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = w_wrap;

endmodule

// File: rtl/am2302_onewire_ctrl.sv
`timescale 1ns/1ps
// am2302_onewire_ctrl
// Single-wire protocol engine for the AM2302 sensor: issues the host start
// pulse on the open-drain DQ line, decodes the 40-bit reply by high-pulse
// width, verifies the checksum and presents humidity/temperature.
// Ports:
//   ACLK, ARESETN         : clock, asynchronous active-low reset
//   start                 : single-cycle measurement request (ignored while busy)
//   busy                  : transaction in progress
//   done                  : single-cycle pulse at the end of every transaction
//   humidity, temperature : last checksum-good readings (raw sensor format)
//   data_valid            : sticky, set by the first good frame
//   checksum_err          : last transaction had a checksum mismatch
//   timeout_err           : last transaction timed out waiting for DQ
//   dq_i                  : DQ pad input (asynchronous)
//   dq_oe                 : 1 drives DQ low, 0 releases it to the pull-up
// Build option: define AM2302_GLITCH_FILTER_EN to add a 3-sample majority
// filter after the synchroniser (rejects 1-cycle glitches, +2 cycles latency).
module am2302_onewire_ctrl
    import am2302_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ   = 100000000,
    parameter int unsigned START_LOW_US  = 1000,
    parameter int unsigned BIT_THRESH_US = 48,
    parameter int unsigned TIMEOUT_US    = 200
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [15:0] humidity,
    output logic [15:0] temperature,
    output logic        data_valid,
    output logic        checksum_err,
    output logic        timeout_err,
    input  logic        dq_i,
    output logic        dq_oe
);

    localparam int unsigned TICK_DIV   = (CLK_FREQ_HZ / 1000000 > 0) ? CLK_FREQ_HZ / 1000000 : 1;
    localparam logic [15:0] L_START_US = 16'(START_LOW_US);
    localparam logic [15:0] L_TIMEOUT  = 16'(TIMEOUT_US);
    localparam logic [16:0] L_THRESH   = 17'(BIT_THRESH_US);
    localparam logic [5:0]  L_LAST_BIT = 6'(FRAME_BITS - 1);

    am2302_state_e         r_state, w_state_next;
    logic                  w_tick;
    logic [1:0]            r_sync;
    logic                  w_dq;
    logic                  r_dq_d;
    logic                  w_fall, w_rise;
    logic [15:0]           r_us_cnt;
    logic [16:0]           w_us_eff;
    logic                  w_bit, w_timeout;
    logic [5:0]            r_bit_cnt;
    logic [FRAME_BITS-1:0] r_frame;
    logic [15:0]           r_humidity, r_temperature;
    logic                  r_valid, r_chk_err, r_to_err;
    logic                  w_dq_oe, w_busy, w_done;

    am2302_us_tick #(.DIV(TICK_DIV)) u_us_tick (
        .i_clk   (ACLK),
        .i_rst_n (ARESETN),
        .o_tick  (w_tick)
    );

    // Synchroniser resets high so an idle (pulled-up) bus shows no edge.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], dq_i};
        end
    end

`ifdef AM2302_GLITCH_FILTER_EN
    logic [1:0] r_hist;
    logic       r_filt;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_hist <= 2'b11;
            r_filt <= 1'b1;
        end else begin
            r_hist <= {r_hist[0], r_sync[1]};
            r_filt <= (r_sync[1] & r_hist[0]) | (r_sync[1] & r_hist[1]) | (r_hist[0] & r_hist[1]);
        end
    end

    assign w_dq = r_filt;
`else
    assign w_dq = r_sync[1];
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_dq_d <= 1'b1;
        end else begin
            r_dq_d <= w_dq;
        end
    end

    assign w_fall = r_dq_d & ~w_dq;
    assign w_rise = ~r_dq_d & w_dq;

    // Including the current cycle's tick makes the measured high time equal
    // the number of ticks across exactly the edge-to-edge cycle count, so a
    // pulse of N us always decodes as N regardless of divider phase.
    assign w_us_eff  = {1'b0, r_us_cnt} + 17'(w_tick);
    assign w_bit     = (w_us_eff >= L_THRESH);
    assign w_timeout = (r_us_cnt >= L_TIMEOUT);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dq_oe      = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (start) w_state_next = START_LOW;
            end
            START_LOW: begin
                w_dq_oe = 1'b1;
                if (r_us_cnt >= L_START_US) w_state_next = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (w_fall)         w_state_next = RESP_LOW;
                else if (w_timeout) w_state_next = DONE;
            end
            RESP_LOW: begin
                if (w_rise)         w_state_next = RESP_HIGH;
                else if (w_timeout) w_state_next = DONE;
            end
            RESP_HIGH: begin
                if (w_fall)         w_state_next = BIT_LOW;
                else if (w_timeout) w_state_next = DONE;
            end
            BIT_LOW: begin
                if (w_rise)         w_state_next = BIT_HIGH;
                else if (w_timeout) w_state_next = DONE;
            end
            BIT_HIGH: begin
                // The fall after the 40th bit is the sensor releasing the bus.
                if (w_fall)         w_state_next = (r_bit_cnt == L_LAST_BIT) ? CHECK : BIT_LOW;
                else if (w_timeout) w_state_next = DONE;
            end
            CHECK: begin
                w_state_next = DONE;
            end
            DONE: begin
                w_busy       = 1'b0;
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_us_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_us_cnt <= '0;
        end else if (w_tick && (r_us_cnt != 16'hFFFF)) begin
            r_us_cnt <= r_us_cnt + 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_bit_cnt     <= '0;
            r_frame       <= '0;
            r_humidity    <= '0;
            r_temperature <= '0;
            r_valid       <= 1'b0;
            r_chk_err     <= 1'b0;
            r_to_err      <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_chk_err <= 1'b0;
                r_to_err  <= 1'b0;
            end
            if ((r_state == RESP_HIGH) && w_fall) begin
                r_bit_cnt <= '0;
            end
            if ((r_state == BIT_HIGH) && w_fall) begin
                r_frame   <= {r_frame[FRAME_BITS-2:0], w_bit};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            // DONE is reached from anywhere but CHECK only through a timeout.
            if ((w_state_next == DONE) && (r_state != CHECK) && (r_state != DONE)) begin
                r_to_err <= 1'b1;
            end
            if (r_state == CHECK) begin
                if (am2302_checksum(r_frame) == r_frame[CSUM_MSB:CSUM_LSB]) begin
                    r_humidity    <= r_frame[HUM_MSB:HUM_LSB];
                    r_temperature <= r_frame[TEMP_MSB:TEMP_LSB];
                    r_valid       <= 1'b1;
                end else begin
                    r_chk_err <= 1'b1;
                end
            end
        end
    end

    assign busy         = w_busy;
    assign done         = w_done;
    assign dq_oe        = w_dq_oe;
    assign humidity     = r_humidity;
    assign temperature  = r_temperature;
    assign data_valid   = r_valid;
    assign checksum_err = r_chk_err;
    assign timeout_err  = r_to_err;

endmodule
